qs_fifo_push_arb: RTL
=====================

QS_FIFO_PUSH_ARB -- requirements
Module: qs_fifo_push_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of each requester's data word and of the FIFO push data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant (1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_i, input, NUM_REQ, per-requester push request, level-held while data is pending.
REQ-007 SHALL have port req_data_i, input, NUM_REQ*DATA_W, requester k data in bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port gnt_o, output, NUM_REQ, one-hot bus-ownership indication.
REQ-009 SHALL have port ack_o, output, NUM_REQ, one-hot pulse: requester's beat is accepted this cycle.
REQ-010 SHALL have port owner_o, output, clog2(NUM_REQ), index of the current or most recent owner.
REQ-011 SHALL have port busy_o, output, 1, high while in GRANT.
REQ-012 SHALL have port fifo_push_o, output, 1, drives the FIFO push strobe.
REQ-013 SHALL have port fifo_push_data_o, output, DATA_W, drives the FIFO push data.
REQ-014 SHALL have port fifo_full_i, input, 1, FIFO full flag.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-016 In IDLE with any req_i bit high, SHALL register as owner the first requesting index scanning upward, with wrap, from last_owner+1; SHALL then enter GRANT on that edge (1-cycle arbitration latency).
REQ-017 In IDLE with req_i==0, SHALL remain in IDLE; gnt_o, ack_o, fifo_push_o SHALL be 0.
REQ-018 In GRANT, gnt_o SHALL be one-hot at owner, decoded from registered state only.
REQ-019 In GRANT, fifo_push_o SHALL equal req_i[owner] AND NOT fifo_full_i (combinational); ack_o[owner] SHALL equal fifo_push_o; all other ack_o bits SHALL be 0.
REQ-020 fifo_push_data_o SHALL be the owner's req_data_i slice in GRANT, and 0 in IDLE.
REQ-021 A beat counter SHALL clear on entry to GRANT and increment on each cycle with fifo_push_o high; it SHALL hold while fifo_full_i is high.
REQ-022 GRANT SHALL exit to IDLE at the edge of the push that brings the beat counter to BURST_LEN.
REQ-023 GRANT SHALL exit to IDLE at the first edge where req_i[owner] is low, with or without fifo_full_i.
REQ-024 With req_i[owner] high and fifo_full_i high, GRANT SHALL hold indefinitely with no push.
REQ-025 On every GRANT exit, last_owner SHALL be loaded with owner; one IDLE bubble cycle SHALL always separate bursts.
REQ-026 Requesters SHALL be served in round-robin order, so a continuously requesting index waits at most NUM_REQ-1 bursts.
REQ-027 Changes in non-owner req_i during GRANT SHALL have no effect until the next IDLE cycle.

Reset
REQ-028 While reset is high, SHALL force state=IDLE, beat counter=0, owner_o=0, last_owner=NUM_REQ-1, busy_o=0, gnt_o=0, ack_o=0, fifo_push_o=0, and fifo_push_data_o=0, independent of clk.
REQ-029 Reset mid-burst SHALL abandon the burst with no further push; after release, requester 0 SHALL have top priority.

Verification (NUM_REQ=4, BURST_LEN=4, DATA_W=8)
REQ-030 Reset release, then req_i=0101 held, fifo_full_i=0 -> cycle 1 IDLE; cycles 2-5 push requester 0 data (4 acks); cycle 6 IDLE; cycles 7-10 push requester 2.
REQ-031 req_i=0001 with requester 0 dropping req after its 2nd ack -> exactly 2 pushes, busy_o falls next edge, no further gnt.
REQ-032 req_i=0010 held, fifo_full_i=1 for 3 cycles after the 2nd beat -> fifo_push_o=0 and gnt_o=0010 throughout the stall; 4 beats total; then IDLE.
REQ-033 req_i=1111 held -> owner_o sequence 0,1,2,3,0, each burst 4 pushes, with one idle cycle between bursts.
REQ-034 req_i=1000 held, async reset pulse during 3rd beat -> all outputs 0 immediately; after release, requester 3 is re-granted after 1 IDLE cycle and fresh bursts of 4 follow.
REQ-035 Data check -> every fifo_push_o cycle carries the owner's req_data_i slice; fifo_push_data_o=0 in every IDLE cycle.

Source files
------------

// File: rtl/qs_fifo_push_arb.sv
// qs_fifo_push_arb: round-robin arbiter that lets one requester at a time
// push up to BURST_LEN beats into a shared FIFO. Two-state FSM (IDLE/GRANT);
// one IDLE bubble always separates consecutive bursts.
module qs_fifo_push_arb #(
  parameter int DATA_W    = 8,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          ack_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        busy_o,
  output logic                        fifo_push_o,
  output logic [DATA_W-1:0]           fifo_push_data_o,
  input  logic                        fifo_full_i
);

  localparam int OWN_W = $clog2(NUM_REQ);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Counter value at which the current push completes the burst.
  localparam logic [7:0] BEAT_LAST = 8'(BURST_LEN - 1);

  logic [0:0]       r_state;
  logic [OWN_W-1:0] r_owner;
  logic [OWN_W-1:0] r_last_owner;
  logic [7:0]       r_beat_cnt;

  logic             w_grant;
  logic             w_own_req;
  logic             w_push;
  logic             w_any_req;
  logic             w_last_beat;
  logic [OWN_W-1:0] w_pick;

  // First requesting index scanning upward (with wrap) from last+1.
  // The scan runs from the farthest offset down to the nearest so the
  // nearest requester overwrites earlier candidates.
  function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [OWN_W-1:0]   last);
    logic [OWN_W-1:0] pick;
    int               k;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(last) + i) % NUM_REQ;
      if (req[k]) pick = k[OWN_W-1:0];
    end
    return pick;
  endfunction

  // Arbitration and output decode; everything here is derived from the
  // registered state plus the live request/full inputs.
  always_comb begin
    w_any_req        = |req_i;
    w_pick           = rr_pick(req_i, r_last_owner);
    w_grant          = (r_state == S_GRANT);
    w_own_req        = req_i[r_owner];
    w_push           = w_grant & w_own_req & ~fifo_full_i;
    w_last_beat      = (r_beat_cnt == BEAT_LAST);

    gnt_o            = '0;
    ack_o            = '0;
    fifo_push_data_o = '0;
    if (w_grant) begin
      gnt_o[r_owner]   = 1'b1;
      ack_o[r_owner]   = w_push;
      fifo_push_data_o = req_data_i[r_owner*DATA_W +: DATA_W];
    end

    fifo_push_o      = w_push;
    busy_o           = w_grant;
    owner_o          = r_owner;
  end

  // FSM, owner registration, burst beat counting and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_owner <= OWN_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_GRANT;
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
          end
        end
        default: begin
          // Leave when the owner withdraws or the final beat is pushed;
          // a full FIFO with the owner still requesting simply holds here.
          if (!w_own_req || (w_push && w_last_beat)) begin
            r_state      <= S_IDLE;
            r_last_owner <= r_owner;
          end
          if (w_push) r_beat_cnt <= r_beat_cnt + 8'd1;
        end
      endcase
    end
  end

endmodule
